mult_error_monitor: RTL and testbench

Sequential stimulus/scoring stage that wraps a combinational `multiplier` candidate (ports A, B, P) during design-space exploration. It generates operand pairs and drives them to the multiplier's A/B inputs. It captures the product returned on P and compares it against an exact internal product. It accumulates the error statistics the RL agent uses as its accuracy reward.

---
 rtl/mult_eval_pkg.sv | 27 ++
 rtl/mult_operand_gen.sv | 43 ++++
 rtl/mult_error_monitor.sv | 133 +++++++++++++
 tb/tb_mult_error_monitor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_eval_pkg.sv
// Shared types and constants for the multiplier error monitor: FSM states,
// LFSR tap masks and the statistics counter width helper.
package mult_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Maximal-length Fibonacci tap masks, bit k set for term x^(k+1).
    function automatic logic [31:0] lfsr_taps(input int n);
        case (n)
            4:       return 32'h0000_000C;  // x^4+x^3+1
            8:       return 32'h0000_00B8;  // x^8+x^6+x^5+x^4+1
            16:      return 32'h0000_B400;  // x^16+x^14+x^13+x^11+1
            32:      return 32'h8020_0003;  // x^32+x^22+x^2+x+1
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic int cnt_width(input longint total);
        return $clog2(total + 1);
    endfunction

endpackage

// File: rtl/mult_operand_gen.sv
// Operand source: 2W-bit Fibonacci LFSR by default, or a 2W-bit up-counter
// covering every operand pair when EXHAUSTIVE_SWEEP_EN is defined.
module mult_operand_gen
    import mult_eval_pkg::*;
#(
    parameter int                 WIDTH = 2,
    parameter logic [2*WIDTH-1:0] SEED  = {{(2*WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               advance,
    output logic [2*WIDTH-1:0] value
);

    localparam int GW = 2 * WIDTH;

`ifdef EXHAUSTIVE_SWEEP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else if (load) begin
            value <= '0;
        end else if (advance) begin
            value <= value + 1'b1;
        end
    end
`else
    localparam logic [GW-1:0] TAPS = GW'(lfsr_taps(GW));

    logic feedback;
    assign feedback = ^(value & TAPS);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            value <= SEED;
        end else if (advance) begin
            value <= {value[GW-2:0], feedback};
        end
    end
`endif

endmodule

// File: rtl/mult_error_monitor.sv
// Drives operand pairs into a candidate multiplier, scores its product against
// the exact one and accumulates error statistics. Build option: EXHAUSTIVE_SWEEP_EN.
module mult_error_monitor
    import mult_eval_pkg::*;
#(
    parameter int                 WIDTH       = 2,
    parameter int                 NUM_VECTORS = 20,
    parameter logic [2*WIDTH-1:0] SEED        = {{(2*WIDTH-1){1'b0}}, 1'b1},
`ifdef EXHAUSTIVE_SWEEP_EN
    localparam longint            TOTAL       = longint'(1) << (2 * WIDTH),
`else
    localparam longint            TOTAL       = longint'(NUM_VECTORS),
`endif
    localparam int                CNT_W       = cnt_width(TOTAL)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [WIDTH-1:0]         op_a,
    output logic [WIDTH-1:0]         op_b,
    input  logic [2*WIDTH-1:0]       prod_in,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         err_count,
    output logic [2*WIDTH-1:0]       max_abs_err,
    output logic [2*WIDTH+CNT_W-1:0] sum_abs_err
);

    localparam int PW = 2 * WIDTH;

    state_t           state, next_state;
    logic             load_src, adv_src;
    logic [CNT_W-1:0] vec_cnt;
    logic             last_vec;
    logic [PW-1:0]    src;
    logic [PW-1:0]    exact;

    logic             cap_valid;
    logic [PW-1:0]    cap_prod, cap_exact;
    logic [PW:0]      diff;
    logic [PW-1:0]    abs_err;

    mult_operand_gen #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (load_src),
        .advance (adv_src),
        .value   (src)
    );

    assign op_a     = src[WIDTH-1:0];
    assign op_b     = src[PW-1:WIDTH];
    assign exact    = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
    assign last_vec = (vec_cnt == CNT_W'(TOTAL - 1));
    assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The source is not advanced on the last vector so it holds through DRAIN/DONE.
    always_comb begin
        next_state = state;
        load_src   = 1'b0;
        adv_src    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    next_state = ST_RUN;
                    load_src   = 1'b1;
                end
            end
            ST_RUN: begin
                if (last_vec) begin
                    next_state = ST_DRAIN;
                end else begin
                    adv_src = 1'b1;
                end
            end
            ST_DRAIN: next_state = ST_DONE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || load_src) begin
            vec_cnt <= '0;
        end else if (adv_src) begin
            vec_cnt <= vec_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || load_src) begin
            cap_valid <= 1'b0;
            cap_prod  <= '0;
            cap_exact <= '0;
        end else begin
            cap_valid <= (state == ST_RUN);
            cap_prod  <= prod_in;
            cap_exact <= exact;
        end
    end

    // Signed difference in PW+1 bits; the magnitude always fits in PW bits.
    assign diff    = {1'b0, cap_prod} - {1'b0, cap_exact};
    assign abs_err = diff[PW] ? (~diff[PW-1:0] + 1'b1) : diff[PW-1:0];

    always_ff @(posedge clk) begin
        if (rst || load_src) begin
            err_count   <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
        end else if (cap_valid) begin
            if (abs_err != '0) begin
                err_count <= err_count + 1'b1;
            end
            if (abs_err > max_abs_err) begin
                max_abs_err <= abs_err;
            end
            sum_abs_err <= sum_abs_err + {{CNT_W{1'b0}}, abs_err};
        end
    end

endmodule

// File: tb/tb_mult_error_monitor.sv
// Directed bench for mult_error_monitor: a 2-bit instance with a selectable
// multiplier stand-in, plus an 8-bit instance for the long LFSR run.
module tb_mult_error_monitor;

`ifdef EXHAUSTIVE_SWEEP_EN
    localparam int N   = 16;
    localparam int CW  = 5;
    localparam int CW8 = 17;
`else
    localparam int N   = 20;
    localparam int CW  = 5;
    localparam int CW8 = 10;
`endif
    localparam int N8 = 1000;

    logic          clk, rst, start, start8;
    logic [1:0]    op_a, op_b;
    logic [3:0]    prod_in, exact_tb;
    logic          busy, done;
    logic [CW-1:0] err_count;
    logic [3:0]    max_abs_err;
    logic [4+CW-1:0] sum_abs_err;

    logic [7:0]       op_a8, op_b8;
    logic [15:0]      prod8;
    logic             busy8, done8;
    logic [CW8-1:0]   err8;
    logic [15:0]      max8;
    logic [16+CW8-1:0] sum8;

    int mode;  // 0 exact, 1 exact+1 mod 16, 2 tied to zero
    int checks, passed;
    logic [3:0] seq_tab [8];

    mult_error_monitor #(.WIDTH(2), .NUM_VECTORS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .prod_in(prod_in), .busy(busy), .done(done), .err_count(err_count),
        .max_abs_err(max_abs_err), .sum_abs_err(sum_abs_err)
    );

    mult_error_monitor #(.WIDTH(8), .NUM_VECTORS(N8), .SEED(16'd1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op_a(op_a8), .op_b(op_b8),
        .prod_in(prod8), .busy(busy8), .done(done8), .err_count(err8),
        .max_abs_err(max8), .sum_abs_err(sum8)
    );

    assign exact_tb = {2'b00, op_a} * {2'b00, op_b};
    assign prod8    = {8'h00, op_a8} * {8'h00, op_b8};

    always_comb begin
        prod_in = exact_tb;
        if (mode == 1) prod_in = exact_tb + 4'd1;
        else if (mode == 2) prod_in = 4'd0;
    end

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0d want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %0d want 0", done); else passed++;
        checks++; if (err_count !== '0) $display("FAIL reset_err: got %0d want 0", err_count); else passed++;
        checks++; if (max_abs_err !== '0) $display("FAIL reset_max: got %0d want 0", max_abs_err); else passed++;
        checks++; if (sum_abs_err !== '0) $display("FAIL reset_sum: got %0d want 0", sum_abs_err); else passed++;
        checks++; if ({op_b, op_a} !== 4'd1) $display("FAIL reset_ops: got %0d want 1", {op_b, op_a}); else passed++;
        checks++; if ({busy8, done8, op_b8, op_a8} !== 18'd1) $display("FAIL reset_dut8: got %0h want 1", {busy8, done8, op_b8, op_a8}); else passed++;
    endtask

    task automatic test_exact();
        mode = 0;
        do_start();
        for (int i = 0; i <= N; i++) begin
            @(negedge clk);
            if (i < 8) begin
                checks++;
                if ({op_b, op_a} !== seq_tab[i]) $display("FAIL exact_vec%0d: got %0d want %0d", i, {op_b, op_a}, seq_tab[i]); else passed++;
            end
            if (i == 0) begin
                checks++; if (busy !== 1'b1) $display("FAIL exact_busy_start: got %0d want 1", busy); else passed++;
            end
            if (i == N) begin
                checks++; if ({busy, done} !== 2'b10) $display("FAIL exact_drain: got busy/done %b want 10", {busy, done}); else passed++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b01) $display("FAIL exact_done: got busy/done %b want 01", {busy, done}); else passed++;
        checks++; if (err_count !== '0) $display("FAIL exact_err: got %0d want 0", err_count); else passed++;
        checks++; if (max_abs_err !== '0) $display("FAIL exact_max: got %0d want 0", max_abs_err); else passed++;
        checks++; if (sum_abs_err !== '0) $display("FAIL exact_sum: got %0d want 0", sum_abs_err); else passed++;
    endtask

    task automatic test_approx();
        mode = 1;
        do_start();
        for (int i = 0; i <= N; i++) begin
            @(negedge clk);
            if (i == N) begin
                checks++; if (done !== 1'b0) $display("FAIL approx_early_done: got %0d want 0", done); else passed++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("FAIL approx_done: got %0d want 1", done); else passed++;
        checks++; if (err_count !== CW'(N)) $display("FAIL approx_err: got %0d want %0d", err_count, N); else passed++;
        checks++; if (max_abs_err !== 4'd1) $display("FAIL approx_max: got %0d want 1", max_abs_err); else passed++;
        checks++; if (sum_abs_err !== 9'(N)) $display("FAIL approx_sum: got %0d want %0d", sum_abs_err, N); else passed++;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({done, err_count} !== {1'b1, CW'(N)}) $display("FAIL approx_hold: got %0h want %0h", {done, err_count}, {1'b1, CW'(N)}); else passed++;
    endtask

    task automatic test_back_to_back();
        mode = 0;
        do_start();
        @(negedge clk);
        checks++; if ({err_count, max_abs_err, sum_abs_err} !== '0) $display("FAIL b2b_clear: got %0h want 0", {err_count, max_abs_err, sum_abs_err}); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %0d want 1", busy); else passed++;
        for (int i = 0; i <= N; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 8) begin
                checks++;
                if ({op_b, op_a} !== seq_tab[i]) $display("FAIL b2b_vec%0d: got %0d want %0d", i, {op_b, op_a}, seq_tab[i]); else passed++;
            end
            if (i == N) begin
                checks++; if ({busy, done} !== 2'b10) $display("FAIL b2b_drain: got busy/done %b want 10", {busy, done}); else passed++;
            end
            if (i == 4) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b01) $display("FAIL b2b_done: got busy/done %b want 01", {busy, done}); else passed++;
        checks++; if ({err_count, max_abs_err, sum_abs_err} !== '0) $display("FAIL b2b_stats: got %0h want 0", {err_count, max_abs_err, sum_abs_err}); else passed++;
    endtask

    task automatic test_reset_midrun();
        mode = 1;
        do_start();
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i == 6) begin
                checks++; if (err_count !== CW'(5)) $display("FAIL midrun_err_before: got %0d want 5", err_count); else passed++;
                rst = 1'b1;
            end
            @(posedge clk);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) $display("FAIL midrun_flags: got busy/done %b want 00", {busy, done}); else passed++;
        checks++; if ({err_count, max_abs_err, sum_abs_err} !== '0) $display("FAIL midrun_stats: got %0h want 0", {err_count, max_abs_err, sum_abs_err}); else passed++;
        checks++; if ({op_b, op_a} !== 4'd1) $display("FAIL midrun_ops: got %0d want 1", {op_b, op_a}); else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({busy, done, op_b, op_a} !== 6'd1) $display("FAIL midrun_idle_hold: got %0h want 1", {busy, done, op_b, op_a}); else passed++;
    endtask

`ifdef EXHAUSTIVE_SWEEP_EN
    task automatic test_exhaustive();
        mode = 2;
        do_start();
        for (int i = 0; i <= N; i++) begin
            @(negedge clk);
            if (i == N) begin
                checks++; if (done !== 1'b0) $display("FAIL sweep_early_done: got %0d want 0", done); else passed++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("FAIL sweep_done: got %0d want 1", done); else passed++;
        checks++; if (err_count !== CW'(9)) $display("FAIL sweep_err: got %0d want 9", err_count); else passed++;
        checks++; if (max_abs_err !== 4'd9) $display("FAIL sweep_max: got %0d want 9", max_abs_err); else passed++;
        checks++; if (sum_abs_err !== 9'd36) $display("FAIL sweep_sum: got %0d want 36", sum_abs_err); else passed++;
        checks++; if ({op_b, op_a} !== 4'd15) $display("FAIL sweep_last_hold: got %0d want 15", {op_b, op_a}); else passed++;
    endtask
`else
    task automatic test_lfsr8();
        int zero_seen;
        zero_seen = 0;
        @(negedge clk);
        start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        for (int i = 0; i <= N8; i++) begin
            @(negedge clk);
            if (i < N8 && op_a8 == 8'd0 && op_b8 == 8'd0) zero_seen++;
            if (i == 0) begin
                checks++; if ({op_b8, op_a8} !== 16'd1) $display("FAIL lfsr8_first: got %0h want 1", {op_b8, op_a8}); else passed++;
            end
            if (i == N8) begin
                checks++; if ({busy8, done8} !== 2'b10) $display("FAIL lfsr8_drain: got busy/done %b want 10", {busy8, done8}); else passed++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++; if ({busy8, done8} !== 2'b01) $display("FAIL lfsr8_done: got busy/done %b want 01", {busy8, done8}); else passed++;
        checks++; if (zero_seen != 0) $display("FAIL lfsr8_zero_pair: got %0d want 0", zero_seen); else passed++;
        checks++; if ({err8, max8, sum8} !== '0) $display("FAIL lfsr8_stats: got %0h want 0", {err8, max8, sum8}); else passed++;
    endtask
`endif

    initial begin
        checks = 0;
        passed = 0;
        mode   = 0;
        rst    = 1'b1;
        start  = 1'b0;
        start8 = 1'b0;
`ifdef EXHAUSTIVE_SWEEP_EN
        for (int i = 0; i < 8; i++) seq_tab[i] = 4'(i);
`else
        // x^4+x^3+1 sequence from seed 1, as {op_b, op_a}
        seq_tab[0] = 4'd1;  seq_tab[1] = 4'd2;  seq_tab[2] = 4'd4;  seq_tab[3] = 4'd9;
        seq_tab[4] = 4'd3;  seq_tab[5] = 4'd6;  seq_tab[6] = 4'd13; seq_tab[7] = 4'd10;
`endif
        test_reset();
        test_exact();
        test_approx();
        test_back_to_back();
        test_reset_midrun();
`ifdef EXHAUSTIVE_SWEEP_EN
        test_exhaustive();
`else
        test_lfsr8();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
